pc_unit: RTL and testbench

- Parametrised program-counter stage for the MIPS core; successor to the plain PC register.
- Owns the PC register and next-PC selection: sequential, branch, jump, jump-register, exception entry, exception return.
- Adds stall hold, synchronous reset to a vector, EPC capture and misaligned-target trapping.
- Sits between the hazard/control logic and instruction memory; pc_out drives the I-mem address directly.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 75 +++++++
 rtl/pc_unit.sv | 109 ++++++++++
 tb/tb_pc_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared constants and state encoding for the MIPS fetch front end.
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int          DEF_WIDTH        = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
  localparam int          DEF_STEP         = 4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_TRAP  = 2'd2
  } pc_state_e;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// pc_next_sel : priority next-PC mux with misaligned-redirect detection.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_sel
  import mips_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               STEP       = DEF_STEP,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_plus_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             stall_i,
  input  logic             exception_i,
  input  logic             eret_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] jr_target_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_i,
  input  logic [WIDTH-1:0] branch_target_i,
  output logic [WIDTH-1:0] next_pc_o,
  output logic             take_trap_o,
  output logic [WIDTH-1:0] fault_addr_o
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic             redirect;
  logic [WIDTH-1:0] target;

  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (jr_i) begin
      redirect = 1'b1;
      target   = jr_target_i;
    end else if (jump_i) begin
      redirect = 1'b1;
      target   = jump_target_i;
    end else if (branch_i) begin
      redirect = 1'b1;
      target   = branch_target_i;
    end
  end

  always_comb begin
    next_pc_o    = pc_plus_i;
    take_trap_o  = 1'b0;
    fault_addr_o = '0;
    if (exception_i) begin
      next_pc_o = EXC_VECTOR;
    end else if (eret_i) begin
      // eret returns to EPC unchecked; EPC may legitimately hold a faulting address
      next_pc_o = epc_i;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end else if (redirect) begin
      if ((target & ALIGN_MASK) != '0) begin
        next_pc_o    = EXC_VECTOR;
        take_trap_o  = 1'b1;
        fault_addr_o = target;
      end else begin
        next_pc_o = target;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit : program-counter register, EPC capture and RESET/RUN/TRAP sequencing.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP         = DEF_STEP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic [WIDTH-1:0] epc_out,
  output logic             adel,
  output logic             fetch_valid
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             adel_q, adel_d;

  logic [WIDTH-1:0] next_pc;
  logic             take_trap;
  logic [WIDTH-1:0] fault_addr;

  assign pc_plus_step = pc_q + WIDTH'(STEP);

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .STEP       (STEP),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .pc_i            (pc_q),
    .pc_plus_i       (pc_plus_step),
    .epc_i           (epc_q),
    .stall_i         (stall),
    .exception_i     (exception),
    .eret_i          (eret),
    .jr_i            (jr),
    .jr_target_i     (jr_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .branch_i        (branch_taken),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc),
    .take_trap_o     (take_trap),
    .fault_addr_o    (fault_addr)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    adel_d  = 1'b0;
    case (state_q)
      // First released edge holds RESET_VECTOR so it becomes the first fetch
      ST_RESET: state_d = ST_RUN;
      ST_RUN, ST_TRAP: begin
        pc_d = next_pc;
        if (exception) begin
          epc_d = pc_q;
        end else if (take_trap) begin
          epc_d  = fault_addr;
          adel_d = 1'b1;
        end
        state_d = (exception || take_trap) ? ST_TRAP : ST_RUN;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      adel_q  <= adel_d;
    end
  end

  assign pc_out      = pc_q;
  assign epc_out     = epc_q;
  assign adel        = adel_q;
  assign fetch_valid = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// tb_pc_unit : directed self-checking bench for pc_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic        eret;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_step;
  logic [31:0] epc_out;
  logic        adel;
  logic        fetch_valid;

  int tests = 0;
  int fails = 0;

  pc_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .exception     (exception),
    .eret          (eret),
    .pc_out        (pc_out),
    .pc_plus_step  (pc_plus_step),
    .epc_out       (epc_out),
    .adel          (adel),
    .fetch_valid   (fetch_valid)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] epc,
                           input logic ad, input logic fv);
    chk({tag, ".pc"},   pc_out, pc);
    chk({tag, ".epc"},  epc_out, epc);
    chk({tag, ".adel"}, {31'd0, adel}, {31'd0, ad});
    chk({tag, ".fv"},   {31'd0, fetch_valid}, {31'd0, fv});
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; exception = 1'b0; eret = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; jr = 1'b0; jr_target = '0;

    // Reset and release: first released edge holds the reset vector
    tick(); chk_state("rst1", 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); chk_state("rst2", 32'h0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(); chk_state("rel1", 32'h0, 32'h0, 1'b0, 1'b1);
    tick(); chk("rel2.pc", pc_out, 32'h4);
    tick(); chk("rel3.pc", pc_out, 32'h8);
    chk("rel3.pps", pc_plus_step, 32'hC);

    // Stall hold then branch
    branch_taken = 1'b1; branch_target = 32'h10;
    tick(); chk("br10.pc", pc_out, 32'h10);
    branch_taken = 1'b0; stall = 1'b1;
    tick(); chk("stall1.pc", pc_out, 32'h10);
    tick(); chk("stall2.pc", pc_out, 32'h10);
    tick(); chk("stall3.pc", pc_out, 32'h10);
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick(); chk("br40.pc", pc_out, 32'h40);
    branch_taken = 1'b0;
    tick(); chk("seq44.pc", pc_out, 32'h44);

    // Misaligned jr traps
    jump = 1'b1; jump_target = 32'h20;
    tick(); chk("j20.pc", pc_out, 32'h20);
    jump = 1'b0; jr = 1'b1; jr_target = 32'h102;
    tick(); chk_state("adel", 32'h8000_0180, 32'h102, 1'b1, 1'b0);
    jr = 1'b0;
    tick(); chk_state("adel_after", 32'h8000_0184, 32'h102, 1'b0, 1'b1);

    // Exception beats jump; eret returns
    jump = 1'b1; jump_target = 32'h200;
    tick(); chk("j200.pc", pc_out, 32'h200);
    exception = 1'b1; jump_target = 32'h300;
    tick(); chk_state("exc", 32'h8000_0180, 32'h200, 1'b0, 1'b0);
    exception = 1'b0; jump = 1'b0;
    tick(); chk_state("exc_after", 32'h8000_0184, 32'h200, 1'b0, 1'b1);
    eret = 1'b1;
    tick(); chk("eret.pc", pc_out, 32'h200);
    eret = 1'b0;
    tick(); chk("eret_seq.pc", pc_out, 32'h204);

    // Wrap at top of address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick(); chk("top.pc", pc_out, 32'hFFFF_FFFC);
    chk("top.pps", pc_plus_step, 32'h0);
    jump = 1'b0;
    tick(); chk_state("wrap", 32'h0, 32'h200, 1'b0, 1'b1);

    // Exception with eret: exception wins and overwrites EPC
    exception = 1'b1; eret = 1'b1;
    tick(); chk_state("exc_eret", 32'h8000_0180, 32'h0, 1'b0, 1'b0);
    // Exception with stall while already in TRAP
    eret = 1'b0; stall = 1'b1;
    tick(); chk_state("exc_stall", 32'h8000_0180, 32'h8000_0180, 1'b0, 1'b0);

    // Reset in the middle of a trap
    stall = 1'b0; reset_n = 1'b0; exception = 1'b0;
    tick(); chk_state("midrst", 32'h0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(); chk_state("midrel", 32'h0, 32'h0, 1'b0, 1'b1);

    // Misalignment checked only on the winning redirect
    jr = 1'b1; jr_target = 32'h50; branch_taken = 1'b1; branch_target = 32'h3;
    tick(); chk_state("prio", 32'h50, 32'h0, 1'b0, 1'b1);
    jr = 1'b0; branch_taken = 1'b0;
    tick(); chk("prio_seq.pc", pc_out, 32'h54);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
